// File: rtl/pcs_tx_pkg.sv
// ----------------------------------------------------------------------------
// pcs_tx_pkg
// Shared 100BASE-X PCS code-group constants. The receive side will import the
// same package, so the 4B/5B table lives here rather than inside the encoder.
//   CODE_WIDTH   width of one code-group (bit 'a' is the MSB)
//   code_t       one 5-bit code-group
//   CODE_I..H    control code-groups (idle, start J/K, end T/R, error H)
//   DATA_CODE    4B/5B data table, indexed by the MII nibble
// ----------------------------------------------------------------------------
package pcs_tx_pkg;

   localparam int CODE_WIDTH = 5;

   typedef logic [CODE_WIDTH-1:0] code_t;

   localparam code_t CODE_I = 5'b11111;
   localparam code_t CODE_J = 5'b11000;
   localparam code_t CODE_K = 5'b10001;
   localparam code_t CODE_T = 5'b01101;
   localparam code_t CODE_R = 5'b00111;
   localparam code_t CODE_H = 5'b00100;

   localparam code_t DATA_CODE [0:15] = '{
      5'b11110, 5'b01001, 5'b10100, 5'b10101,
      5'b01010, 5'b01011, 5'b01110, 5'b01111,
      5'b10010, 5'b10011, 5'b10110, 5'b10111,
      5'b11010, 5'b11011, 5'b11100, 5'b11101
   };

endpackage

// File: rtl/pcs_4b5b_encode.sv
// ----------------------------------------------------------------------------
// pcs_4b5b_encode
// Purely combinational 4B/5B data encoder (nibble -> code-group).
//   nibble_i  in  4  MII data nibble
//   code_o    out 5  matching data code-group, bit 'a' in the MSB
// ----------------------------------------------------------------------------
module pcs_4b5b_encode
   import pcs_tx_pkg::*;
(
   input  logic [3:0] nibble_i,
   output code_t      code_o
);

   assign code_o = DATA_CODE[nibble_i];

endmodule

// File: rtl/pcs_tx.sv
// ----------------------------------------------------------------------------
// pcs_tx
// 100BASE-X PCS transmit. Takes MII TX nibbles on each mii_tx_ce, frames them
// with J/K and T/R, fills gaps with IDLE, 4B/5B-encodes the data and shifts
// one code-group bit per clk towards the PMA (optionally NRZI-coded).
//   clk          in   clock (125 MHz, one code-group bit per cycle)
//   rst          in   asynchronous, active-high reset
//   mii_tx_ce    in   nibble strobe; MII inputs are sampled where it is high
//   mii_tx_en    in   MII TX_EN
//   mii_txd      in   MII TXD nibble
//   mii_tx_er    in   MII TX_ER (only honoured inside DATA)
//   pma_tx_data  out  serial code-group bit, bit 'a' first
//   tx_active    out  high while J..R code-groups are being shifted out
//   align_err    out  one-clk pulse: ce arrived before the current group ended
// ----------------------------------------------------------------------------
module pcs_tx
   import pcs_tx_pkg::*;
#(
   parameter bit NRZI     = 1'b0,
   parameter int CE_RATIO = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mii_tx_ce,
   input  logic       mii_tx_en,
   input  logic [3:0] mii_txd,
   input  logic       mii_tx_er,
   output logic       pma_tx_data,
   output logic       tx_active,
   output logic       align_err
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_START_K = 2'd1;
   localparam logic [1:0] ST_DATA    = 2'd2;
   localparam logic [1:0] ST_END_R   = 2'd3;

   // Bits left after the first one when a code-group is loaded.
   localparam logic [2:0] CNT_LOAD = 3'(CE_RATIO - 1);

   logic [1:0] state_q,  state_d;
   code_t      shift_q,  shift_d;
   logic [2:0] count_q,  count_d;
   logic       pma_q,    pma_d;
   logic       active_q, active_d;
   logic       r_in_q,   r_in_d;    // shifter currently holds R
   logic       align_q,  align_d;

   code_t      data_code;
   code_t      load_code;

   pcs_4b5b_encode u_encode (
      .nibble_i (mii_txd),
      .code_o   (data_code)
   );

   // Framing FSM: picks the code-group for this ce and the next state.
   // NOTE: every output of a combinational block gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      load_code = CODE_I;
      case (state_q)
         ST_IDLE: begin
            if (mii_tx_en) begin
               load_code = CODE_J;
               state_d   = ST_START_K;
            end
         end
         ST_START_K: begin
            if (mii_tx_en) begin
               load_code = CODE_K;
               state_d   = ST_DATA;
            end else begin
               load_code = CODE_T;   // runt: K never sent
               state_d   = ST_END_R;
            end
         end
         ST_DATA: begin
            if (mii_tx_en) begin
               load_code = mii_tx_er ? CODE_H : data_code;
            end else begin
               load_code = CODE_T;
               state_d   = ST_END_R;
            end
         end
         ST_END_R: begin
            load_code = CODE_R;      // en ignored; a J follows on the next ce
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (!mii_tx_ce) begin
         state_d = state_q;
      end
   end

   // Shifter, bit count and status flags.
   always_comb begin
      shift_d  = shift_q;
      count_d  = count_q;
      active_d = active_q;
      r_in_d   = r_in_q;
      align_d  = 1'b0;
      if (mii_tx_ce) begin
         // A load always wins; an early ce truncates the current group.
         shift_d = load_code;
         count_d = CNT_LOAD;
         r_in_d  = (load_code == CODE_R);
         align_d = (count_q != 3'd0);
         if (load_code == CODE_J) begin
            active_d = 1'b1;
         end else if (r_in_q) begin
            active_d = 1'b0;
         end
      end else if (count_q != 3'd0) begin
         shift_d = {shift_q[CODE_WIDTH-2:0], 1'b1};
         count_d = count_q - 3'd1;
      end else begin
         // Last bit went out with no new nibble: keep idling.
         shift_d = CODE_I;
         r_in_d  = 1'b0;
         if (r_in_q) begin
            active_d = 1'b0;
         end
      end
      pma_d = NRZI ? (pma_q ^ shift_q[CODE_WIDTH-1]) : shift_q[CODE_WIDTH-1];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shift_q  <= CODE_I;
         count_q  <= 3'd0;
         pma_q    <= 1'b0;
         active_q <= 1'b0;
         r_in_q   <= 1'b0;
         align_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         count_q  <= count_d;
         pma_q    <= pma_d;
         active_q <= active_d;
         r_in_q   <= r_in_d;
         align_q  <= align_d;
      end
   end

   assign pma_tx_data = pma_q;
   assign tx_active   = active_q;
   assign align_err   = align_q;

endmodule
